// File: rtl/cfnt_bank_read_unmap_if.sv
// Bank-read return bus for cfnt_bank_read_unmap.
// The slave side is the unmap block. The master side is whatever drives the banks
// and consumes the lane-ordered words.
interface cfnt_bank_read_unmap_if #(
   parameter int DATA_WIDTH = 12
);
   logic                  in_valid;
   logic [1:0]            bank_number_0;
   logic [1:0]            bank_number_1;
   logic [1:0]            bank_number_2;
   logic [1:0]            bank_number_3;
   logic [DATA_WIDTH-1:0] bank_rdata_0;
   logic [DATA_WIDTH-1:0] bank_rdata_1;
   logic [DATA_WIDTH-1:0] bank_rdata_2;
   logic [DATA_WIDTH-1:0] bank_rdata_3;
   logic                  conflict_clr;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] lane_rdata_0;
   logic [DATA_WIDTH-1:0] lane_rdata_1;
   logic [DATA_WIDTH-1:0] lane_rdata_2;
   logic [DATA_WIDTH-1:0] lane_rdata_3;
   logic                  conflict;

   modport slave (
      input  in_valid, bank_number_0, bank_number_1, bank_number_2, bank_number_3,
      input  bank_rdata_0, bank_rdata_1, bank_rdata_2, bank_rdata_3, conflict_clr,
      output out_valid, lane_rdata_0, lane_rdata_1, lane_rdata_2, lane_rdata_3, conflict
   );

   modport master (
      output in_valid, bank_number_0, bank_number_1, bank_number_2, bank_number_3,
      output bank_rdata_0, bank_rdata_1, bank_rdata_2, bank_rdata_3, conflict_clr,
      input  out_valid, lane_rdata_0, lane_rdata_1, lane_rdata_2, lane_rdata_3, conflict
   );
endinterface

// File: rtl/cfnt_bank_read_unmap.sv
// Return path of the conflict-free memory map.
// Bank indices are delayed by RD_LATENCY cycles (legal 1..4) so that they line up with the
// bank read data. A registered 4x4 crossbar then puts each bank word back into lane order.
// Optional feature: define CFNT_UNMAP_CONFLICT_CHECK_EN to build the sticky conflict
// detector. Without it, conflict is tied low and conflict_clr is ignored.
module cfnt_bank_read_unmap #(
   parameter int DATA_WIDTH = 12,
   parameter int RD_LATENCY = 1
) (
   input logic                   clk,
   input logic                   rst,
   cfnt_bank_read_unmap_if.slave bus
);

   logic [1:0]            idx_in  [4];
   logic [DATA_WIDTH-1:0] data_in [4];
   logic                  valid_q [RD_LATENCY];
   logic [1:0]            idx_q   [RD_LATENCY][4];
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] lane_q  [4];
   logic                  conflict_q;

   assign idx_in[0]  = bus.bank_number_0;
   assign idx_in[1]  = bus.bank_number_1;
   assign idx_in[2]  = bus.bank_number_2;
   assign idx_in[3]  = bus.bank_number_3;
   assign data_in[0] = bus.bank_rdata_0;
   assign data_in[1] = bus.bank_rdata_1;
   assign data_in[2] = bus.bank_rdata_2;
   assign data_in[3] = bus.bank_rdata_3;

   // Delay line: stage 0 samples the request, later stages shift every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the delay line is reset, unlike a data RAM. A stale valid bit here would
         // otherwise emit a phantom out_valid after reset.
         for (int s = 0; s < RD_LATENCY; s++) begin
            valid_q[s] <= 1'b0;
            for (int k = 0; k < 4; k++) idx_q[s][k] <= 2'd0;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage read its neighbour's old value,
         // so the loop order does not matter.
         valid_q[0] <= bus.in_valid;
         for (int k = 0; k < 4; k++) idx_q[0][k] <= idx_in[k];
         for (int s = 1; s < RD_LATENCY; s++) begin
            valid_q[s] <= valid_q[s-1];
            for (int k = 0; k < 4; k++) idx_q[s][k] <= idx_q[s-1][k];
         end
      end
   end

   // Registered crossbar: each lane selects any bank, so duplicate indices are allowed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         for (int k = 0; k < 4; k++) lane_q[k] <= '0;
      end else begin
         out_valid_q <= valid_q[RD_LATENCY-1];
         // NOTE: the hold on a bubble is a clock-enable on a flop. The same "if" in
         // combinational logic would infer a latch.
         if (valid_q[RD_LATENCY-1]) begin
            for (int k = 0; k < 4; k++) lane_q[k] <= data_in[idx_q[RD_LATENCY-1][k]];
         end
      end
   end

`ifdef CFNT_UNMAP_CONFLICT_CHECK_EN
   logic dup;

   // Any pair of lanes naming the same bank in the sampled request
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int j = i + 1; j < 4; j++) begin
            if (idx_in[i] == idx_in[j]) dup = 1'b1;
         end
      end
   end

   // Sticky flag: a new conflict takes priority over a clear in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        conflict_q <= 1'b0;
      else if (bus.in_valid && dup)   conflict_q <= 1'b1;
      else if (bus.conflict_clr)      conflict_q <= 1'b0;
   end
`else
   logic unused_conflict_clr;
   assign unused_conflict_clr = bus.conflict_clr;
   assign conflict_q          = 1'b0;
`endif

   assign bus.out_valid    = out_valid_q;
   assign bus.lane_rdata_0 = lane_q[0];
   assign bus.lane_rdata_1 = lane_q[1];
   assign bus.lane_rdata_2 = lane_q[2];
   assign bus.lane_rdata_3 = lane_q[3];
   assign bus.conflict     = conflict_q;

endmodule

// File: tb/tb_cfnt_bank_read_unmap.sv
// Bench for cfnt_bank_read_unmap. It runs two instances, with RD_LATENCY=1 and
// RD_LATENCY=3, on the same stimulus. A history-based model predicts every output cycle.
// Directed literal checks pin the model.
module tb_cfnt_bank_read_unmap;
   localparam int DW   = 12;
   localparam int MAXC = 1024;
`ifdef CFNT_UNMAP_CONFLICT_CHECK_EN
   localparam bit CONF_EN = 1'b1;
`else
   localparam bit CONF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid;
   logic [1:0]    bn [4];
   logic [DW-1:0] bd [4];
   logic          clr;
   int            n_checks = 0;
   int            n_errors = 0;
   int            seq = 0;

   always #5 clk = ~clk;

   cfnt_bank_read_unmap_if #(.DATA_WIDTH(DW)) if1 ();
   cfnt_bank_read_unmap_if #(.DATA_WIDTH(DW)) if3 ();

   assign if1.in_valid = in_valid;       assign if3.in_valid = in_valid;
   assign if1.bank_number_0 = bn[0];     assign if3.bank_number_0 = bn[0];
   assign if1.bank_number_1 = bn[1];     assign if3.bank_number_1 = bn[1];
   assign if1.bank_number_2 = bn[2];     assign if3.bank_number_2 = bn[2];
   assign if1.bank_number_3 = bn[3];     assign if3.bank_number_3 = bn[3];
   assign if1.bank_rdata_0 = bd[0];      assign if3.bank_rdata_0 = bd[0];
   assign if1.bank_rdata_1 = bd[1];      assign if3.bank_rdata_1 = bd[1];
   assign if1.bank_rdata_2 = bd[2];      assign if3.bank_rdata_2 = bd[2];
   assign if1.bank_rdata_3 = bd[3];      assign if3.bank_rdata_3 = bd[3];
   assign if1.conflict_clr = clr;        assign if3.conflict_clr = clr;

   cfnt_bank_read_unmap #(.DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   cfnt_bank_read_unmap #(.DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

   // Outputs of both instances gathered as arrays: index 0 is latency 1, index 1 is latency 3
   logic          act_v [2];
   logic [DW-1:0] act_l [2][4];
   logic          act_c [2];
   always_comb begin
      act_v[0] = if1.out_valid;  act_c[0] = if1.conflict;
      act_v[1] = if3.out_valid;  act_c[1] = if3.conflict;
      act_l[0][0] = if1.lane_rdata_0; act_l[0][1] = if1.lane_rdata_1;
      act_l[0][2] = if1.lane_rdata_2; act_l[0][3] = if1.lane_rdata_3;
      act_l[1][0] = if3.lane_rdata_0; act_l[1][1] = if3.lane_rdata_1;
      act_l[1][2] = if3.lane_rdata_2; act_l[1][3] = if3.lane_rdata_3;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit has_dup(input logic [1:0] a, b, c, e);
      return (a == b) || (a == c) || (a == e) || (b == c) || (b == e) || (c == e);
   endfunction

   // ---------------- model: request/data history per clock edge ----------------
   logic          hv [MAXC];
   logic [1:0]    hi [MAXC][4];
   logic [DW-1:0] hd [MAXC][4];
   logic [DW-1:0] exp_l [2][4];
   logic          exp_c = 1'b0;
   int            lat [2] = '{1, 3};
   int            n = 0;
   int            last_rst = 0;

   // At each edge n, record cycle n's inputs, then predict what is visible in cycle n+1.
   // A request in cycle r appears in cycle r+L+1 and carries the bank words of cycle r+L.
   always @(posedge clk) begin
      n = n + 1;
      hv[n] = in_valid;
      for (int k = 0; k < 4; k++) begin
         hi[n][k] = bn[k];
         hd[n][k] = bd[k];
      end
      if (rst) begin
         last_rst = n;
         exp_c = 1'b0;
      end else if (CONF_EN && in_valid && has_dup(bn[0], bn[1], bn[2], bn[3])) begin
         exp_c = 1'b1;
      end else if (CONF_EN && clr) begin
         exp_c = 1'b0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         int  r;
         logic ev;
         r  = n - lat[d];
         ev = 1'b0;
         if (!rst && r > last_rst) ev = hv[r];
         for (int k = 0; k < 4; k++) begin
            if (rst)     exp_l[d][k] = '0;
            else if (ev) exp_l[d][k] = hd[n][hi[r][k]];
         end
         check($sformatf("model L%0d out_valid cyc%0d", lat[d], n + 1), 32'(act_v[d]), 32'(ev));
         for (int k = 0; k < 4; k++)
            check($sformatf("model L%0d lane%0d cyc%0d", lat[d], k, n + 1),
                  32'(act_l[d][k]), 32'(exp_l[d][k]));
         check($sformatf("model L%0d conflict cyc%0d", lat[d], n + 1), 32'(act_c[d]), 32'(exp_c));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drv(input logic v, input logic [1:0] a, b, c, e,
                      input logic [DW-1:0] w, x, y, z, input logic cl);
      in_valid = v;
      bn[0] = a; bn[1] = b; bn[2] = c; bn[3] = e;
      bd[0] = w; bd[1] = x; bd[2] = y; bd[3] = z;
      clr = cl;
   endtask

   // Same as drv, but the bank words come from a running pattern
   task automatic drv_a(input logic v, input logic [1:0] a, b, c, e, input logic cl);
      seq++;
      drv(v, a, b, c, e, DW'(seq * 37 + 1), DW'(seq * 37 + 2), DW'(seq * 37 + 3),
          DW'(seq * 37 + 4), cl);
   endtask

   initial begin
      int cnt;
      int first;
      drv(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, '0, '0, '0, '0, 1'b0);
      tick(); tick();
      // Reset state
      check("reset out_valid", 32'(act_v[0]), 32'h0);
      check("reset lane0", 32'(act_l[1][0]), 32'h0);
      check("reset conflict", 32'(act_c[0]), 32'h0);
      rst = 1'b0;
      tick(); tick();

      // Permute, latency 1
      tick(); drv_a(1'b1, 2'd2, 2'd3, 2'd0, 2'd1, 1'b0);
      tick(); drv(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 12'h0A0, 12'h0B1, 12'h0C2, 12'h0D3, 1'b0);
      tick();
      check("permute out_valid", 32'(act_v[0]), 32'h1);
      check("permute lane0", 32'(act_l[0][0]), 32'h0C2);
      check("permute lane1", 32'(act_l[0][1]), 32'h0D3);
      check("permute lane2", 32'(act_l[0][2]), 32'h0A0);
      check("permute lane3", 32'(act_l[0][3]), 32'h0B1);
      drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      repeat (4) begin tick(); drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); end

      // Streaming: 8 back-to-back rotating requests; latency-3 valid window
      cnt = 0; first = -1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (act_v[1] === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
         end
         if (i < 8) drv_a(1'b1, 2'(i), 2'(i + 1), 2'(i + 2), 2'(i + 3), 1'b0);
         else       drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      end
      check("stream valid cycles", 32'(cnt), 32'd8);
      check("stream first valid offset", 32'(first), 32'd4);

      // Bubble, latency 1: valid 1,0,1 in, 1,0,1 out, data held through the gap
      tick(); drv_a(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
      tick(); drv(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0);
      tick();
      check("bubble first valid", 32'(act_v[0]), 32'h1);
      check("bubble first lane2", 32'(act_l[0][2]), 32'h333);
      drv_a(1'b1, 2'd3, 2'd2, 2'd1, 2'd0, 1'b0);
      tick();
      check("bubble gap valid", 32'(act_v[0]), 32'h0);
      check("bubble gap lane0 hold", 32'(act_l[0][0]), 32'h111);
      check("bubble gap lane3 hold", 32'(act_l[0][3]), 32'h444);
      drv(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 12'h555, 12'h666, 12'h777, 12'h888, 1'b0);
      tick();
      check("bubble second valid", 32'(act_v[0]), 32'h1);
      check("bubble second lane0", 32'(act_l[0][0]), 32'h888);
      check("bubble second lane3", 32'(act_l[0][3]), 32'h555);
      drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      repeat (4) begin tick(); drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); end

      // Conflict: duplicate indices, clear, and set-beats-clear
      tick(); drv_a(1'b1, 2'd1, 2'd1, 2'd2, 2'd3, 1'b0);
      tick();
      check("conflict set", 32'(act_c[0]), 32'(CONF_EN));
      drv(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 12'h0A0, 12'h0A1, 12'h0A2, 12'h0A3, 1'b0);
      tick();
      check("dup lane0", 32'(act_l[0][0]), 32'h0A1);
      check("dup lane1", 32'(act_l[0][1]), 32'h0A1);
      check("dup lane2", 32'(act_l[0][2]), 32'h0A2);
      drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
      tick();
      check("conflict cleared", 32'(act_c[0]), 32'h0);
      drv_a(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
      tick();
      check("conflict set wins over clr", 32'(act_c[1]), 32'(CONF_EN));
      drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
      tick(); drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      repeat (4) begin tick(); drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); end

      // Mid-stream reset with in_valid held high, then a single post-reset request
      for (int i = 0; i < 5; i++) begin
         tick(); drv_a(1'b1, 2'(i), 2'(i + 2), 2'(i + 1), 2'(i + 3), 1'b0);
      end
      tick();
      check("pre-reset streaming valid", 32'(act_v[1]), 32'h1);
      drv_a(1'b1, 2'd1, 2'd1, 2'd3, 2'd3, 1'b0);
      rst = 1'b1;
      #1;
      check("async reset out_valid L1", 32'(act_v[0]), 32'h0);
      check("async reset out_valid L3", 32'(act_v[1]), 32'h0);
      check("async reset lane1 L3", 32'(act_l[1][1]), 32'h0);
      check("async reset conflict", 32'(act_c[0]), 32'h0);
      tick(); tick();
      rst = 1'b0;
      drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      cnt = 0;
      repeat (8) begin
         tick();
         if (act_v[0] === 1'b1 || act_v[1] === 1'b1) cnt++;
         drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      end
      check("no stale out_valid after reset", 32'(cnt), 32'd0);
      tick(); drv_a(1'b1, 2'd3, 2'd0, 2'd1, 2'd2, 1'b0);
      repeat (6) begin tick(); drv_a(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
